// File: rtl/mode_extremum_tracker_pkg.sv
// mode_cmp_pkg: shared FSM states, mode encodings and default width for the MAX/MIN trackers
package mode_cmp_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    localparam logic MODE_MAX = 1'b0;
    localparam logic MODE_MIN = 1'b1;
    localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/mode_better_cmp.sv
// mode_better_cmp: strict unsigned better-than test (cand > cur for MAX, cand < cur for MIN)
// ports: cand, cur (WIDTH samples), mode (0 MAX / 1 MIN) -> better
module mode_better_cmp
    import mode_cmp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] cand,
    input  logic [WIDTH-1:0] cur,
    input  logic             mode,
    output logic             better
);
    assign better = (mode == MODE_MIN) ? (cand < cur) : (cand > cur);
endmodule

// File: rtl/mode_extremum_tracker.sv
// mode_extremum_tracker: reduces a FRAME_LEN-sample stream to its MAX or MIN value and index
// ports: clk, rst_n (async low); start/m request a frame; din/in_valid/in_ready sample stream;
//        y/y_idx/out_valid/out_ready result stream; busy = not IDLE
module mode_extremum_tracker
    import mode_cmp_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int FRAME_LEN = 4,
    localparam int IDX_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             m,
    input  logic [WIDTH-1:0] din,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] y,
    output logic [IDX_W-1:0] y_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);
    state_t           state, nxt;
    logic [IDX_W-1:0] cnt;
    logic             mode, better, acc, last;

    assign in_ready  = state == ACCUM;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;
    assign acc       = in_valid && in_ready;
    assign last      = cnt == IDX_W'(FRAME_LEN - 1);

    mode_better_cmp #(.WIDTH(WIDTH)) u_cmp (
        .cand  (din),
        .cur   (y),
        .mode  (mode),
        .better(better)
    );

    always_comb begin
        nxt = state;
        nxt = (state == IDLE)  ? (start ? ACCUM : IDLE) :
              (state == ACCUM) ? ((acc && last) ? DONE : ACCUM) :
                                 (out_ready ? IDLE : DONE);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= nxt;

    // the first sample of a frame loads unconditionally; later ones only on a strict win,
    // so ties keep the earliest index
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            y     <= '0;
            y_idx <= '0;
            cnt   <= '0;
            mode  <= MODE_MAX;
        end else if (state == IDLE && start) begin
            mode <= m;
            cnt  <= '0;
        end else if (acc) begin
            if (cnt == '0 || better) begin
                y     <= din;
                y_idx <= cnt;
            end
            cnt <= last ? '0 : cnt + IDX_W'(1);
        end
endmodule

// File: doc/mode_extremum_tracker.md
Name: mode_extremum_tracker

Overview:
Sequential counterpart to the team's combinational MAX/MIN comparator. It consumes a frame of FRAME_LEN samples over a valid/ready stream and reduces them to a single MAX or MIN result, selected by mode m. It returns the winning value and the index of the sample that supplied it. It sits between a sample source and a result consumer, with backpressure on both sides.

Parameters:
WIDTH, 8, sample and result width in bits
FRAME_LEN, 4, samples per frame; legal range 1..255
IDX_W, max(1, clog2(FRAME_LEN)), width of the index and counter (derived localparam)

Ports:
clk  input  1  single clock; all logic on its rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  request a new frame; honoured only in IDLE
m  input  1  mode, sampled on the accepted start: 0 = MAX, 1 = MIN
din  input  WIDTH  sample, unsigned
in_valid  input  1  din is valid
in_ready  output  1  block accepts din this cycle
y  output  WIDTH  reduced result
y_idx  output  IDX_W  0-based frame index of the sample that produced y
out_valid  output  1  y and y_idx are valid
out_ready  input  1  consumer accepts the result
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state = IDLE
  - y = 0, y_idx = 0, counter = 0, latched mode = 0
  - out_valid = 0, in_ready = 0, busy = 0
- FSM states: IDLE, ACCUM, DONE. Encode as registers; outputs depend on registered state only.
- IDLE:
  - in_ready = 0, out_valid = 0.
  - When start = 1: latch m, clear the counter, go to ACCUM on the next cycle.
- ACCUM:
  - in_ready = 1. A sample is accepted when in_valid && in_ready.
  - First accepted sample (counter = 0): unconditionally loads y = din and y_idx = 0.
  - Each later sample replaces y and y_idx = counter only when strictly better: din > y for MAX, din < y for MIN (unsigned compare).
  - Ties keep the earliest index.
  - Counter increments per accepted sample. Cycles with in_valid = 0 do not count.
  - On acceptance of sample FRAME_LEN-1: go to DONE. out_valid rises the following cycle, with y and y_idx final. Latency is 1 cycle from the last handshake.
  - FRAME_LEN = 1: the first sample goes straight to DONE.
- DONE:
  - out_valid = 1, in_ready = 0.
  - y, y_idx and out_valid are held stable until out_ready = 1.
  - On out_valid && out_ready: go to IDLE next cycle; out_valid drops that cycle.
- start outside IDLE is ignored and is not queued. This includes start coinciding with the output handshake.
- A change of m mid-frame has no effect; only the value latched at start applies.
- Reset asserted mid-frame or mid-DONE: immediate return to reset values; the partial frame is discarded.
- No overflow is possible: y is a selected sample, never a sum. The counter never exceeds FRAME_LEN-1.

Decomposition:
- Shared package mode_cmp_pkg holds:
  - state typedef {IDLE, ACCUM, DONE}
  - constants MODE_MAX = 1'b0, MODE_MIN = 1'b1
  - default WIDTH
- One natural sub-module: mode_better_cmp. It is combinational, WIDTH-parameterised, with inputs cand, cur, mode and output better (strict > or <). It is instantiated once for the replace decision.

Test Plan:
- m=0, samples 33,122,167,4, out_ready=1 -> y=167, y_idx=2; out_valid high exactly 1 cycle after the 4th handshake.
- m=1, samples 112,103,132,141 -> y=103, y_idx=1; busy drops the cycle after the output handshake.
- Ties, m=0, samples 68,68,5,68 -> y=68, y_idx=0. Ties, m=1, samples 5,5,5,5 -> y=5, y_idx=0.
- Gaps and backpressure: in_valid toggled 1,0,0,1,0,1,1 with values 10,x,x,200,x,7,255, m=0 -> y=255, y_idx=3. Hold out_ready=0 for 5 cycles:
  - y, y_idx and out_valid stay stable
  - in_ready = 0
  - start pulses are ignored (busy stays 1)
- Reset mid-frame: after accepting 2 samples, pulse rst_n low asynchronously -> y=0, y_idx=0, out_valid=0, busy=0 at once. The next frame (m=1) with 9,3,3,200 gives y=3, y_idx=1.
- FRAME_LEN=1 build: start, then a single sample 42 -> y=42, y_idx=0, out_valid on the next cycle.
